// File: rtl/stdp_pkg.sv
// rtl/stdp_pkg.sv - shared types, case-bit indices, LFSR taps and saturating step helper
package stdp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int CAPTURE = 0;
  localparam int MINUS   = 1;
  localparam int SEARCH  = 2;
  localparam int BACKOFF = 3;

  localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;

  // One step up or down, clamped to [0, wmax]; conflicting or absent requests hold.
  function automatic logic [7:0] sat_step(input logic [7:0] w, input logic [7:0] wmax,
                                          input logic inc, input logic dec);
    logic [7:0] r;
    r = w;
    if (inc && !dec && (w != wmax)) r = w + 8'd1;
    else if (dec && !inc && (w != 8'd0)) r = w - 8'd1;
    return r;
  endfunction

endpackage

// File: rtl/stdp_weight_update_if.sv
// rtl/stdp_weight_update_if.sv - request, threshold, write and weight signals of the update engine
interface stdp_weight_update_if #(
  parameter int NSYN  = 8,
  parameter int WBITS = 3,
  parameter int PBITS = 8
);
  logic                      start;
  logic [4*NSYN-1:0]         stdp_cases;
  logic [PBITS-1:0]          capture_prob;
  logic [PBITS-1:0]          minus_prob;
  logic [PBITS-1:0]          search_prob;
  logic [PBITS-1:0]          backoff_prob;
  logic [PBITS-1:0]          min_prob;
  logic                      wr_en;
  logic [$clog2(NSYN)-1:0]   wr_addr;
  logic [WBITS-1:0]          wr_data;
  logic                      busy;
  logic                      done;
  logic [NSYN*WBITS-1:0]     weights;

  modport master (
    output start, stdp_cases, capture_prob, minus_prob, search_prob, backoff_prob, min_prob,
    output wr_en, wr_addr, wr_data,
    input  busy, done, weights
  );

  modport slave (
    input  start, stdp_cases, capture_prob, minus_prob, search_prob, backoff_prob, min_prob,
    input  wr_en, wr_addr, wr_data,
    output busy, done, weights
  );
endinterface

// File: rtl/stdp_lfsr.sv
// rtl/stdp_lfsr.sv - right-shifting Galois LFSR that advances only when enabled
module stdp_lfsr #(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] SEED  = 32'hACE1_2468,
  parameter logic [WIDTH-1:0] TAPS  = 32'h8020_0003
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  // Shift right; the bit falling out of the bottom folds back in through the tap mask.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= SEED;
    else if (en) q <= q[0] ? ((q >> 1) ^ TAPS) : (q >> 1);
  end

endmodule

// File: rtl/stdp_weight_update.sv
// rtl/stdp_weight_update.sv - serial STDP weight-update engine (optional: STDP_STABILIZE_EN)
module stdp_weight_update
  import stdp_pkg::*;
#(
  parameter int                NSYN      = 8,
  parameter int                WBITS     = 3,
  parameter int                PBITS     = 8,
  parameter int                LFSR_W    = 32,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 32'hACE1_2468,
  parameter int                W_INIT    = 0
) (
  input logic                 clk,
  input logic                 rst_n,
  stdp_weight_update_if.slave bus
);

  localparam int IBITS = $clog2(NSYN);
  localparam int WMAX  = (1 << WBITS) - 1;
  localparam int SHIFT = PBITS - WBITS;

  state_t              r_state;
  state_t              w_next_state;
  logic [IBITS-1:0]    r_idx;
  logic [4*NSYN-1:0]   r_cases;
  logic [PBITS-1:0]    r_capture_prob;
  logic [PBITS-1:0]    r_minus_prob;
  logic [PBITS-1:0]    r_search_prob;
  logic [PBITS-1:0]    r_backoff_prob;
  logic [WBITS-1:0]    r_w [NSYN];

  logic [LFSR_W-1:0]   w_rnd;
  logic                w_sweep;
  logic                w_accept;
  logic [WBITS-1:0]    w_cur;
  logic [WBITS-1:0]    w_new;
  logic [3:0]          w_case;
  logic [PBITS-1:0]    w_r_case;
  logic                w_capture_brv;
  logic                w_minus_brv;
  logic                w_search_brv;
  logic                w_backoff_brv;
  logic                w_stab_inc;
  logic                w_stab_dec;
  logic                w_inc;
  logic                w_dec;
  logic                w_unused;

  assign w_sweep  = (r_state == ST_SWEEP);
  assign w_accept = (r_state == ST_IDLE) && bus.start;

  stdp_lfsr #(
    .WIDTH (LFSR_W),
    .SEED  (LFSR_SEED),
    .TAPS  (LFSR_W'(LFSR_TAPS_32))
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (w_sweep),
    .q     (w_rnd)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else r_state <= w_next_state;
  end

  // Next state: a start outside IDLE is simply dropped.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (bus.start) w_next_state = ST_SWEEP;
      ST_SWEEP: if (r_idx == IBITS'(NSYN - 1)) w_next_state = ST_DONE;
      ST_DONE:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // Synapse pointer: cleared on an accepted start, stepped once per sweep cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_idx <= '0;
    else if (w_accept) r_idx <= '0;
    else if (w_sweep) r_idx <= r_idx + IBITS'(1);
  end

  // Snapshot case bits and thresholds so the sweep is immune to input changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cases        <= '0;
      r_capture_prob <= '0;
      r_minus_prob   <= '0;
      r_search_prob  <= '0;
      r_backoff_prob <= '0;
    end else if (w_accept) begin
      r_cases        <= bus.stdp_cases;
      r_capture_prob <= bus.capture_prob;
      r_minus_prob   <= bus.minus_prob;
      r_search_prob  <= bus.search_prob;
      r_backoff_prob <= bus.backoff_prob;
    end
  end

  assign w_cur    = r_w[r_idx];
  assign w_case   = r_cases[4*r_idx +: 4];
  assign w_r_case = w_rnd[PBITS-1:0];

  assign w_capture_brv = (w_r_case < r_capture_prob);
  assign w_minus_brv   = (w_r_case < r_minus_prob);
  assign w_search_brv  = (w_r_case < r_search_prob);
  assign w_backoff_brv = (w_r_case < r_backoff_prob);

`ifdef STDP_STABILIZE_EN
  logic [PBITS-1:0] r_min_prob;
  logic [PBITS-1:0] w_r_min;
  logic [PBITS-1:0] w_r_fout;
  logic [PBITS-1:0] w_fout_inc;
  logic [PBITS-1:0] w_fout_dec;
  logic             w_min_brv;

  // Minimum-update threshold is only needed when stabilisation is built in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_min_prob <= '0;
    else if (w_accept) r_min_prob <= bus.min_prob;
  end

  // Heavier weights are harder to raise and easier to lower, and vice versa.
  assign w_r_min    = w_rnd[2*PBITS-1:PBITS];
  assign w_r_fout   = w_rnd[3*PBITS-1:2*PBITS];
  assign w_fout_inc = PBITS'(WBITS'(WMAX) - w_cur) << SHIFT;
  assign w_fout_dec = PBITS'(w_cur) << SHIFT;
  assign w_min_brv  = (w_r_min < r_min_prob);
  assign w_stab_inc = (w_r_fout < w_fout_inc) | w_min_brv;
  assign w_stab_dec = (w_r_fout < w_fout_dec) | w_min_brv;
`else
  assign w_stab_inc = 1'b1;
  assign w_stab_dec = 1'b1;
`endif

  // Random bits outside the used slices, and min_prob in the plain build, are don't-cares.
  assign w_unused = ^{w_rnd, bus.min_prob};

  assign w_inc = (w_case[CAPTURE] & w_capture_brv & w_stab_inc) |
                 (w_case[SEARCH] & w_search_brv);
  assign w_dec = (w_case[MINUS] & w_minus_brv & w_stab_dec) |
                 (w_case[BACKOFF] & w_backoff_brv & w_stab_dec);
  assign w_new = WBITS'(sat_step(8'(w_cur), 8'(WMAX), w_inc, w_dec));

  // Weight bank: host writes only in IDLE (landing before a same-cycle sweep), sweep updates one per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NSYN; i++) r_w[i] <= WBITS'(W_INIT);
    end else if ((r_state == ST_IDLE) && bus.wr_en) begin
      r_w[bus.wr_addr] <= bus.wr_data;
    end else if (w_sweep) begin
      r_w[r_idx] <= w_new;
    end
  end

  for (genvar g = 0; g < NSYN; g++) begin : g_weights
    assign bus.weights[WBITS*g +: WBITS] = r_w[g];
  end

  assign bus.busy = (r_state != ST_IDLE);
  assign bus.done = (r_state == ST_DONE);

endmodule

// File: tb/tb_stdp_weight_update.sv
// tb/tb_stdp_weight_update.sv - scoreboard bench for stdp_weight_update (follows STDP_STABILIZE_EN)
module tb_stdp_weight_update;

  localparam int          NSYN   = 8;
  localparam int          WBITS  = 3;
  localparam int          PBITS  = 8;
  localparam int          W_INIT = 3;
  localparam int          WMAX   = 7;
  localparam logic [31:0] SEED   = 32'hACE1_2468;
  localparam logic [31:0] TAPS   = 32'h8020_0003;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stdp_weight_update_if #(.NSYN(NSYN), .WBITS(WBITS), .PBITS(PBITS)) bus ();

  stdp_weight_update #(
    .NSYN(NSYN), .WBITS(WBITS), .PBITS(PBITS), .LFSR_W(32), .LFSR_SEED(SEED), .W_INIT(W_INIT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;
  int mw [NSYN];
  logic [31:0] mlfsr;
  logic [NSYN*WBITS-1:0] exp_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NSYN*WBITS-1:0] pack_model();
    logic [NSYN*WBITS-1:0] v;
    v = '0;
    for (int i = 0; i < NSYN; i++) v[WBITS*i +: WBITS] = WBITS'(mw[i]);
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NSYN; i++) mw[i] = W_INIT;
    mlfsr = SEED;
  endtask

  task automatic model_sweep(input logic [4*NSYN-1:0] cs, input int cp, input int mp,
                             input int sp, input int bp, input int minp);
    int rc, rm, rf, w;
    bit cap, mi, se, bo, si, sd, inc, dec;
    for (int i = 0; i < NSYN; i++) begin
      rc = int'(mlfsr[7:0]);
      rm = int'(mlfsr[15:8]);
      rf = int'(mlfsr[23:16]);
      w = mw[i];
      cap = cs[4*i];
      mi = cs[4*i+1];
      se = cs[4*i+2];
      bo = cs[4*i+3];
`ifdef STDP_STABILIZE_EN
      si = (rf < (WMAX - w) * 32) || (rm < minp);
      sd = (rf < w * 32) || (rm < minp);
`else
      si = 1'b1;
      sd = 1'b1;
      if (rm < 0 || rf < 0 || minp < 0) si = 1'b1;
`endif
      inc = (cap && (rc < cp) && si) || (se && (rc < sp));
      dec = (mi && (rc < mp) && sd) || (bo && (rc < bp) && sd);
      if (inc && !dec && w < WMAX) mw[i] = w + 1;
      else if (dec && !inc && w > 0) mw[i] = w - 1;
      mlfsr = mlfsr[0] ? ((mlfsr >> 1) ^ TAPS) : (mlfsr >> 1);
    end
  endtask

  task automatic idle_inputs();
    bus.start = 1'b0;
    bus.stdp_cases = '0;
    bus.capture_prob = '0;
    bus.minus_prob = '0;
    bus.search_prob = '0;
    bus.backoff_prob = '0;
    bus.min_prob = '0;
    bus.wr_en = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
  endtask

  task automatic write_w(input int a, input int d);
    @(negedge clk);
    bus.wr_en = 1'b1;
    bus.wr_addr = 3'(a);
    bus.wr_data = 3'(d);
    @(negedge clk);
    bus.wr_en = 1'b0;
    mw[a] = d;
  endtask

  task automatic write_all(input int d);
    for (int i = 0; i < NSYN; i++) write_w(i, d);
  endtask

  task automatic do_sweep(input logic [4*NSYN-1:0] cs, input int cp, input int mp, input int sp,
                          input int bp, input int minp, input bit do_wr, input int wa, input int wd,
                          input bit inject, input bit timing);
    int lat, busy_cnt;
    bit got;
    logic [2:0] bad_wd;
    if (do_wr) mw[wa] = wd;
    model_sweep(cs, cp, mp, sp, bp, minp);
    exp_q.push_back(pack_model());
    bad_wd = 3'(mw[0]) ^ 3'b101;
    @(negedge clk);
    bus.stdp_cases = cs;
    bus.capture_prob = 8'(cp);
    bus.minus_prob = 8'(mp);
    bus.search_prob = 8'(sp);
    bus.backoff_prob = 8'(bp);
    bus.min_prob = 8'(minp);
    bus.wr_en = do_wr;
    bus.wr_addr = 3'(wa);
    bus.wr_data = 3'(wd);
    bus.start = 1'b1;
    lat = 0;
    busy_cnt = 0;
    got = 1'b0;
    for (int c = 0; c < 4 * NSYN && !got; c++) begin
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.wr_en = 1'b0;
      bus.stdp_cases = '0;
      bus.capture_prob = '0;
      lat++;
      if (bus.busy) busy_cnt++;
      if (bus.done) got = 1'b1;
      else if (inject && lat == 3) begin
        bus.start = 1'b1;
        bus.wr_en = 1'b1;
        bus.wr_addr = '0;
        bus.wr_data = bad_wd;
      end
    end
    if (!got) begin
      check("done_timeout", 64'd0, 64'd1);
      void'(exp_q.pop_front());
    end else begin
      check("weights", 64'(bus.weights), 64'(exp_q.pop_front()));
      if (timing) begin
        check("done_latency", 64'(lat), 64'(NSYN + 1));
        check("busy_cycles", 64'(busy_cnt), 64'(NSYN + 1));
      end
    end
    @(posedge clk);
    #1;
    if (timing) check("done_one_cycle", 64'(bus.done), 64'd0);
    if (inject) check("start_ignored_busy", 64'(bus.busy), 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4*NSYN-1:0] cs;
    int inc_cnt;
    idle_inputs();
    model_reset();

    // Reset values
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    check("reset_weights", 64'(bus.weights), 64'(pack_model()));
    @(negedge clk);
    rst_n = 1'b1;

    // Direct writes to zero
    write_all(0);
    @(posedge clk);
    #1;
    check("write_zero", 64'(bus.weights), 64'(pack_model()));

    // Deterministic increment up to saturation, first sweep also checks timing
    for (int s = 0; s < 8; s++)
      do_sweep({NSYN{4'b0100}}, 0, 0, 255, 0, 0, 1'b0, 0, 0, 1'b0, s == 0);
    check("inc_saturated", 64'(bus.weights), 64'({NSYN{3'd7}}));

    // Decrement to the floor
    for (int s = 0; s < 8; s++)
      do_sweep({NSYN{4'b1000}}, 0, 0, 0, 255, 255, 1'b0, 0, 0, 1'b0, 1'b0);

    // Capture at WMAX never exceeds WMAX
    write_all(WMAX);
    for (int s = 0; s < 3; s++)
      do_sweep({NSYN{4'b0001}}, 255, 0, 0, 0, 0, 1'b0, 0, 0, 1'b0, 1'b0);
    check("capture_at_wmax", 64'(bus.weights), 64'({NSYN{3'd7}}));

    // Start and write injected mid-sweep are ignored
    do_sweep({NSYN{4'b0100}}, 0, 0, 128, 0, 0, 1'b0, 0, 0, 1'b1, 1'b1);

    // Conflicting cases on synapses 2 and 3
    write_all(4);
    cs = '0;
    cs[4*2 +: 4] = 4'b0110;
    cs[4*3 +: 4] = 4'b0101;
    for (int s = 0; s < 2; s++)
      do_sweep(cs, 255, 255, 255, 0, 255, 1'b0, 0, 0, 1'b0, 1'b0);

    // Capture at 0.5 with write on the start cycle
    inc_cnt = 0;
    for (int s = 0; s < 1000; s++) begin
      do_sweep({{(NSYN-1){4'b0000}}, 4'b0001}, 128, 0, 0, 0, 255, 1'b1, 0, 0, 1'b0, 1'b0);
      if (bus.weights[2:0] == 3'd1) inc_cnt++;
    end
    $display("capture increments: %0d of 1000", inc_cnt);
    check("inc_rate_in_band", 64'(inc_cnt >= 450 && inc_cnt <= 550), 64'd1);

    // Reset in the middle of a sweep
    write_all(0);
    @(negedge clk);
    bus.stdp_cases = {NSYN{4'b0100}};
    bus.search_prob = 8'd255;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check("midreset_weights", 64'(bus.weights), 64'(pack_model()));
    check("midreset_busy", 64'(bus.busy), 64'd0);
    check("midreset_done", 64'(bus.done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_inputs();
    do_sweep({NSYN{4'b0001}}, 200, 0, 0, 0, 100, 1'b0, 0, 0, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
